// File: rtl/power_rail_sequencer.sv
// Board power rail sequencer: ATX supply, FET gates, POL inhibits, MGT rails.
// Stages step up in order, gated by power-goods, and step down in reverse.
// A power-good that never arrives during power-up forces every rail off at once.
//
// Ports:
//   wb_clk_i / wb_rst_i              clock, asynchronous active-high reset
//   power_up / power_down            1-cycle command strobes (power_down also clears a fault)
//   power_up_done / power_down_done  1-cycle completion pulses
//   busy, fault, fault_stage, seq_state  status (seq_state: OFF=0 UP=1 ON=2 DOWN=3 FAULT=4)
//   ATX_*, G*_EN, TRACK_2V5, INHIBIT_*, MGT_*_EN  rail controls (registered, glitch-free)
//   ATX_PWR_OK, AUX_3V3_PG, MGT_*_PG  power-good inputs
//
// Build option: define PWR_SEQ_PG_MONITOR_EN to also watch the gating power-goods
// while ON; a power-good low for PG_DEGLITCH consecutive cycles forces a fault.
module power_rail_sequencer #(
  parameter logic [31:0] STEP_WAIT   = 32'h0003_ffff,
  parameter logic [31:0] PG_TIMEOUT  = 32'h003f_ffff,
  parameter logic [7:0]  PG_DEGLITCH = 8'd16
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       power_up,
  input  logic       power_down,
  output logic       power_up_done,
  output logic       power_down_done,
  output logic       busy,
  output logic       fault,
  output logic [3:0] fault_stage,
  output logic [2:0] seq_state,
  output logic       ATX_PS_ON_N,
  input  logic       ATX_PWR_OK,
  output logic       G12V_EN,
  output logic       G5V_EN,
  output logic       G3V3_EN,
  input  logic       AUX_3V3_PG,
  output logic       TRACK_2V5,
  output logic       INHIBIT_2V5,
  output logic       INHIBIT_1V8,
  output logic       INHIBIT_1V5,
  output logic       INHIBIT_1V2,
  output logic       INHIBIT_1V0,
  output logic       MGT_AVCC_EN,
  output logic       MGT_AVTTX_EN,
  output logic       MGT_AVCCPLL_EN,
  input  logic       MGT_AVCC_PG,
  input  logic       MGT_AVTTX_PG,
  input  logic       MGT_AVCCPLL_PG
);

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_UP    = 3'd1,
    ST_ON    = 3'd2,
    ST_DOWN  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  typedef struct packed {
    logic atx_ps_on_n;
    logic g12v_en;
    logic g5v_en;
    logic g3v3_en;
    logic inhibit_2v5;
    logic track_2v5;
    logic inhibit_1v8;
    logic inhibit_1v5;
    logic inhibit_1v2;
    logic inhibit_1v0;
    logic mgt_avcc_en;
    logic mgt_avttx_en;
    logic mgt_avccpll_en;
  } rails_t;

  // Stage k means stages 1..k are active; stage 0 is everything off.
  function automatic rails_t decode_rails(input logic [3:0] stg);
    rails_t r;
    r.atx_ps_on_n    = !(stg >= 4'd1);
    r.g12v_en        =  (stg >= 4'd2);
    r.g5v_en         =  (stg >= 4'd3);
    r.g3v3_en        =  (stg >= 4'd4);
    r.inhibit_2v5    = !(stg >= 4'd5);
    r.track_2v5      =  (stg >= 4'd5);
    r.inhibit_1v8    = !(stg >= 4'd6);
    r.inhibit_1v5    = !(stg >= 4'd7);
    r.inhibit_1v2    = !(stg >= 4'd8);
    r.inhibit_1v0    = !(stg >= 4'd9);
    r.mgt_avcc_en    =  (stg >= 4'd10);
    r.mgt_avttx_en   =  (stg >= 4'd11);
    r.mgt_avccpll_en =  (stg >= 4'd12);
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  stage_q, stage_d;
  logic [31:0] dwell_q, dwell_d;
  logic [31:0] pgwait_q, pgwait_d;
  logic        up_done_q, up_done_d;
  logic        dn_done_q, dn_done_d;
  logic        fault_q, fault_d;
  logic [3:0]  fault_stage_q, fault_stage_d;
  rails_t      rails_q, rails_d;
  logic        gate_ok;

  // Power-good gating the current stage; ungated stages always pass.
  always_comb begin
    gate_ok = 1'b1;
    case (stage_q)
      4'd1:    gate_ok = ATX_PWR_OK;
      4'd4:    gate_ok = AUX_3V3_PG;
      4'd10:   gate_ok = MGT_AVCC_PG;
      4'd11:   gate_ok = MGT_AVTTX_PG;
      4'd12:   gate_ok = MGT_AVCCPLL_PG;
      default: gate_ok = 1'b1;
    endcase
  end

`ifdef PWR_SEQ_PG_MONITOR_EN
  // Index 0..4 maps to gating stages 1, 4, 10, 11, 12.
  logic [4:0]      pg_vec;
  logic [4:0][7:0] deg_q, deg_d;
  logic [4:0]      trip;
  logic            mon_fault;
  logic [3:0]      mon_stage;

  assign pg_vec = {MGT_AVCCPLL_PG, MGT_AVTTX_PG, MGT_AVCC_PG, AUX_3V3_PG, ATX_PWR_OK};

  always_comb begin
    deg_d     = '0;
    trip      = '0;
    mon_fault = 1'b0;
    mon_stage = 4'd0;
    for (int i = 0; i < 5; i++) begin
      if (state_q == ST_ON && !pg_vec[i]) begin
        deg_d[i] = (deg_q[i] == 8'hff) ? 8'hff : deg_q[i] + 8'd1;
        trip[i]  = (deg_d[i] >= PG_DEGLITCH);
      end
    end
    // Lowest stage index wins when several rails drop together.
    if      (trip[0]) begin mon_fault = 1'b1; mon_stage = 4'd1;  end
    else if (trip[1]) begin mon_fault = 1'b1; mon_stage = 4'd4;  end
    else if (trip[2]) begin mon_fault = 1'b1; mon_stage = 4'd10; end
    else if (trip[3]) begin mon_fault = 1'b1; mon_stage = 4'd11; end
    else if (trip[4]) begin mon_fault = 1'b1; mon_stage = 4'd12; end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) deg_q <= '0;
    else          deg_q <= deg_d;
  end
`endif

  always_comb begin
    state_d       = state_q;
    stage_d       = stage_q;
    dwell_d       = dwell_q;
    pgwait_d      = pgwait_q;
    up_done_d     = 1'b0;
    dn_done_d     = 1'b0;
    fault_d       = 1'b0;
    fault_stage_d = fault_stage_q;

    case (state_q)
      ST_OFF: begin
        if (power_up && !power_down) begin
          state_d  = ST_UP;
          stage_d  = 4'd1;
          dwell_d  = '0;
          pgwait_d = '0;
        end
      end
      ST_UP: begin
        if (power_down) begin
          state_d = ST_DOWN;
          dwell_d = '0;
        end else if (dwell_q < STEP_WAIT) begin
          dwell_d = dwell_q + 32'd1;
        end else if (gate_ok) begin
          if (stage_q == 4'd12) begin
            state_d   = ST_ON;
            up_done_d = 1'b1;
          end else begin
            stage_d  = stage_q + 4'd1;
            dwell_d  = '0;
            pgwait_d = '0;
          end
        end else if (pgwait_q >= PG_TIMEOUT) begin
          state_d       = ST_FAULT;
          stage_d       = 4'd0;
          fault_d       = 1'b1;
          fault_stage_d = stage_q;
        end else begin
          pgwait_d = pgwait_q + 32'd1;
        end
      end
      ST_ON: begin
        if (power_down) begin
          state_d = ST_DOWN;
          dwell_d = '0;
        end
`ifdef PWR_SEQ_PG_MONITOR_EN
        else if (mon_fault) begin
          state_d       = ST_FAULT;
          stage_d       = 4'd0;
          fault_d       = 1'b1;
          fault_stage_d = mon_stage;
        end
`endif
      end
      ST_DOWN: begin
        if (dwell_q < STEP_WAIT) begin
          dwell_d = dwell_q + 32'd1;
        end else if (stage_q <= 4'd1) begin
          state_d   = ST_OFF;
          stage_d   = 4'd0;
          dn_done_d = 1'b1;
        end else begin
          stage_d = stage_q - 4'd1;
          dwell_d = '0;
        end
      end
      ST_FAULT: begin
        if (power_down) begin
          state_d   = ST_OFF;
          dn_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_OFF;
        stage_d = 4'd0;
      end
    endcase

    // Decoding the next stage puts rail changes on the same edge as the stage change.
    rails_d = decode_rails(stage_d);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q       <= ST_OFF;
      stage_q       <= 4'd0;
      dwell_q       <= '0;
      pgwait_q      <= '0;
      up_done_q     <= 1'b0;
      dn_done_q     <= 1'b0;
      fault_q       <= 1'b0;
      fault_stage_q <= 4'd0;
      rails_q       <= decode_rails(4'd0);
    end else begin
      state_q       <= state_d;
      stage_q       <= stage_d;
      dwell_q       <= dwell_d;
      pgwait_q      <= pgwait_d;
      up_done_q     <= up_done_d;
      dn_done_q     <= dn_done_d;
      fault_q       <= fault_d;
      fault_stage_q <= fault_stage_d;
      rails_q       <= rails_d;
    end
  end

  assign power_up_done   = up_done_q;
  assign power_down_done = dn_done_q;
  assign fault           = fault_q;
  assign fault_stage     = fault_stage_q;
  assign seq_state       = state_q;
  assign busy            = (state_q == ST_UP) || (state_q == ST_DOWN);

  assign ATX_PS_ON_N    = rails_q.atx_ps_on_n;
  assign G12V_EN        = rails_q.g12v_en;
  assign G5V_EN         = rails_q.g5v_en;
  assign G3V3_EN        = rails_q.g3v3_en;
  assign INHIBIT_2V5    = rails_q.inhibit_2v5;
  assign TRACK_2V5      = rails_q.track_2v5;
  assign INHIBIT_1V8    = rails_q.inhibit_1v8;
  assign INHIBIT_1V5    = rails_q.inhibit_1v5;
  assign INHIBIT_1V2    = rails_q.inhibit_1v2;
  assign INHIBIT_1V0    = rails_q.inhibit_1v0;
  assign MGT_AVCC_EN    = rails_q.mgt_avcc_en;
  assign MGT_AVTTX_EN   = rails_q.mgt_avttx_en;
  assign MGT_AVCCPLL_EN = rails_q.mgt_avccpll_en;

endmodule

// File: tb/tb_power_rail_sequencer.sv
// Self-checking bench for power_rail_sequencer with short timing parameters.
// Expected rail patterns come from the stage order table; expected timing is
// computed from the dwell / timeout / deglitch rules with plain arithmetic.
module tb_power_rail_sequencer;

  localparam int SW = 4;
  localparam int TO = 20;
  localparam int DG = 3;

  // Stage that activates each rail (bit order of dut_rails) and its polarity.
  localparam int RAIL_STAGE [13] = '{1, 2, 3, 4, 5, 5, 6, 7, 8, 9, 10, 11, 12};
  localparam bit RAIL_LOW   [13] = '{1, 0, 0, 0, 1, 0, 1, 1, 1, 1, 0, 0, 0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       power_up = 1'b0, power_down = 1'b0;
  logic       power_up_done, power_down_done, busy, fault;
  logic [3:0] fault_stage;
  logic [2:0] seq_state;
  logic       ATX_PS_ON_N, G12V_EN, G5V_EN, G3V3_EN, TRACK_2V5;
  logic       INHIBIT_2V5, INHIBIT_1V8, INHIBIT_1V5, INHIBIT_1V2, INHIBIT_1V0;
  logic       MGT_AVCC_EN, MGT_AVTTX_EN, MGT_AVCCPLL_EN;
  logic       ATX_PWR_OK = 1'b0, AUX_3V3_PG = 1'b0;
  logic       MGT_AVCC_PG = 1'b0, MGT_AVTTX_PG = 1'b0, MGT_AVCCPLL_PG = 1'b0;

  int checks = 0;
  int errors = 0;
  int up_cnt = 0, dn_cnt = 0, flt_cnt = 0;

  power_rail_sequencer #(
    .STEP_WAIT  (32'(SW)),
    .PG_TIMEOUT (32'(TO)),
    .PG_DEGLITCH(8'(DG))
  ) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .power_up       (power_up),
    .power_down     (power_down),
    .power_up_done  (power_up_done),
    .power_down_done(power_down_done),
    .busy           (busy),
    .fault          (fault),
    .fault_stage    (fault_stage),
    .seq_state      (seq_state),
    .ATX_PS_ON_N    (ATX_PS_ON_N),
    .ATX_PWR_OK     (ATX_PWR_OK),
    .G12V_EN        (G12V_EN),
    .G5V_EN         (G5V_EN),
    .G3V3_EN        (G3V3_EN),
    .AUX_3V3_PG     (AUX_3V3_PG),
    .TRACK_2V5      (TRACK_2V5),
    .INHIBIT_2V5    (INHIBIT_2V5),
    .INHIBIT_1V8    (INHIBIT_1V8),
    .INHIBIT_1V5    (INHIBIT_1V5),
    .INHIBIT_1V2    (INHIBIT_1V2),
    .INHIBIT_1V0    (INHIBIT_1V0),
    .MGT_AVCC_EN    (MGT_AVCC_EN),
    .MGT_AVTTX_EN   (MGT_AVTTX_EN),
    .MGT_AVCCPLL_EN (MGT_AVCCPLL_EN),
    .MGT_AVCC_PG    (MGT_AVCC_PG),
    .MGT_AVTTX_PG   (MGT_AVTTX_PG),
    .MGT_AVCCPLL_PG (MGT_AVCCPLL_PG)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [12:0] dut_rails();
    return {MGT_AVCCPLL_EN, MGT_AVTTX_EN, MGT_AVCC_EN, INHIBIT_1V0, INHIBIT_1V2,
            INHIBIT_1V5, INHIBIT_1V8, TRACK_2V5, INHIBIT_2V5, G3V3_EN, G5V_EN,
            G12V_EN, ATX_PS_ON_N};
  endfunction

  // Reference: rail levels for "stages 1..s active".
  function automatic logic [12:0] exp_rails(input int s);
    logic [12:0] r;
    for (int i = 0; i < 13; i++) begin
      r[i] = RAIL_LOW[i] ? !(s >= RAIL_STAGE[i]) : (s >= RAIL_STAGE[i]);
    end
    return r;
  endfunction

  function automatic bit is_gated(input int s);
    return (s == 1) || (s == 4) || (s >= 10);
  endfunction

  // Advance one clock and sample #1 after the edge, tallying output pulses.
  task automatic step();
    @(posedge clk);
    #1;
    if (power_up_done)   up_cnt++;
    if (power_down_done) dn_cnt++;
    if (fault)           flt_cnt++;
  endtask

  task automatic set_all_pg(input logic v);
    ATX_PWR_OK = v; AUX_3V3_PG = v;
    MGT_AVCC_PG = v; MGT_AVTTX_PG = v; MGT_AVCCPLL_PG = v;
  endtask

  task automatic raise_pg(input int s);
    case (s)
      1:  ATX_PWR_OK     = 1'b1;
      4:  AUX_3V3_PG     = 1'b1;
      10: MGT_AVCC_PG    = 1'b1;
      11: MGT_AVTTX_PG   = 1'b1;
      12: MGT_AVCCPLL_PG = 1'b1;
      default: ;
    endcase
  endtask

  task automatic pulse_up();
    power_up = 1'b1;
    step();
    power_up = 1'b0;
  endtask

  task automatic pulse_down();
    power_down = 1'b1;
    step();
    power_down = 1'b0;
  endtask

  // From OFF, run up to stage n (13 = ON) with the gating PGs as currently driven high.
  task automatic advance_to_stage(input int n);
    pulse_up();
    repeat ((n - 1) * (SW + 1)) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (dut_rails() !== exp_rails(0)) begin
      errors++; $display("FAIL reset_rails: got %b want %b", dut_rails(), exp_rails(0));
    end
    checks++;
    if (seq_state !== 3'd0 || busy !== 1'b0 || fault_stage !== 4'd0) begin
      errors++; $display("FAIL reset_status: state %0d busy %b fstage %0d want 0 0 0",
                         seq_state, busy, fault_stage);
    end
    checks++;
    if (power_up_done !== 1'b0 || power_down_done !== 1'b0 || fault !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: up %b down %b fault %b want 0 0 0",
                         power_up_done, power_down_done, fault);
    end
    rst = 1'b0;
    step();
  endtask

  // Random power-good arrival per gated stage: the stage advances on the edge
  // after max(SW, d) cycles, where d is the cycle the PG is first seen high.
  task automatic test_power_up();
    int d, t;
    set_all_pg(1'b0);
    up_cnt = 0;
    pulse_up();
    for (int s = 1; s <= 12; s++) begin
      d = is_gated(s) ? int'($urandom_range(0, SW + TO)) : 0;
      t = ((d > SW) ? d : SW) + 1;
      for (int j = 0; j < t; j++) begin
        if (is_gated(s) && j == d) raise_pg(s);
        if (j == t - 1) begin
          checks++;
          if (dut_rails() !== exp_rails(s) || seq_state !== 3'd1 || busy !== 1'b1) begin
            errors++; $display("FAIL up_hold s%0d d%0d: rails %b state %0d busy %b want %b 1 1",
                               s, d, dut_rails(), seq_state, busy, exp_rails(s));
          end
        end
        step();
      end
      if (s < 12) begin
        checks++;
        if (dut_rails() !== exp_rails(s + 1) || seq_state !== 3'd1) begin
          errors++; $display("FAIL up_adv s%0d: rails %b state %0d want %b 1",
                             s, dut_rails(), seq_state, exp_rails(s + 1));
        end
      end else begin
        checks++;
        if (seq_state !== 3'd2 || power_up_done !== 1'b1 || busy !== 1'b0 ||
            dut_rails() !== exp_rails(12)) begin
          errors++; $display("FAIL up_on: state %0d done %b busy %b rails %b want 2 1 0 %b",
                             seq_state, power_up_done, busy, dut_rails(), exp_rails(12));
        end
      end
    end
    pulse_up();
    repeat (3) step();
    checks++;
    if (seq_state !== 3'd2 || up_cnt !== 1) begin
      errors++; $display("FAIL up_once: state %0d up_pulses %0d want 2 1", seq_state, up_cnt);
    end
  endtask

  task automatic test_power_down();
    dn_cnt = 0;
    pulse_down();
    checks++;
    if (seq_state !== 3'd3 || dut_rails() !== exp_rails(12)) begin
      errors++; $display("FAIL dn_enter: state %0d rails %b want 3 %b",
                         seq_state, dut_rails(), exp_rails(12));
    end
    for (int s = 12; s >= 1; s--) begin
      for (int j = 0; j <= SW; j++) begin
        {ATX_PWR_OK, AUX_3V3_PG, MGT_AVCC_PG, MGT_AVTTX_PG, MGT_AVCCPLL_PG} = 5'($urandom);
        if (j == SW) begin
          checks++;
          if (dut_rails() !== exp_rails(s) || seq_state !== 3'd3) begin
            errors++; $display("FAIL dn_hold s%0d: rails %b state %0d want %b 3",
                               s, dut_rails(), seq_state, exp_rails(s));
          end
        end
        step();
      end
      checks++;
      if (dut_rails() !== exp_rails(s - 1)) begin
        errors++; $display("FAIL dn_adv s%0d: rails %b want %b", s, dut_rails(), exp_rails(s - 1));
      end
    end
    checks++;
    if (seq_state !== 3'd0 || power_down_done !== 1'b1) begin
      errors++; $display("FAIL dn_off: state %0d done %b want 0 1", seq_state, power_down_done);
    end
    set_all_pg(1'b1);
    repeat (3) step();
    checks++;
    if (dn_cnt !== 1 || busy !== 1'b0 || dut_rails() !== exp_rails(0)) begin
      errors++; $display("FAIL dn_once: pulses %0d busy %b rails %b want 1 0 %b",
                         dn_cnt, busy, dut_rails(), exp_rails(0));
    end
  endtask

  task automatic test_pg_timeout();
    set_all_pg(1'b1);
    MGT_AVTTX_PG = 1'b0;
    flt_cnt = 0;
    advance_to_stage(11);
    repeat (SW + TO) step();
    checks++;
    if (seq_state !== 3'd1 || dut_rails() !== exp_rails(11) || fault !== 1'b0) begin
      errors++; $display("FAIL to_wait: state %0d rails %b fault %b want 1 %b 0",
                         seq_state, dut_rails(), fault, exp_rails(11));
    end
    step();
    checks++;
    if (seq_state !== 3'd4 || fault !== 1'b1 || fault_stage !== 4'd11 ||
        dut_rails() !== exp_rails(0) || busy !== 1'b0) begin
      errors++; $display("FAIL to_fault: state %0d fault %b fstage %0d rails %b busy %b want 4 1 11 %b 0",
                         seq_state, fault, fault_stage, dut_rails(), busy, exp_rails(0));
    end
    pulse_up();
    repeat (2) step();
    checks++;
    if (seq_state !== 3'd4 || flt_cnt !== 1 || dut_rails() !== exp_rails(0)) begin
      errors++; $display("FAIL to_ignore_up: state %0d faults %0d rails %b want 4 1 %b",
                         seq_state, flt_cnt, dut_rails(), exp_rails(0));
    end
    pulse_down();
    checks++;
    if (seq_state !== 3'd0 || power_down_done !== 1'b1) begin
      errors++; $display("FAIL to_clear: state %0d done %b want 0 1", seq_state, power_down_done);
    end
    MGT_AVTTX_PG = 1'b1;
    step();
  endtask

  task automatic test_abort_during_up();
    int r;
    set_all_pg(1'b1);
    up_cnt = 0;
    advance_to_stage(6);
    r = int'($urandom_range(0, SW));
    repeat (r) step();
    power_up = 1'b1; power_down = 1'b1;
    step();
    power_up = 1'b0; power_down = 1'b0;
    checks++;
    if (seq_state !== 3'd3 || dut_rails() !== exp_rails(6)) begin
      errors++; $display("FAIL abort_enter r%0d: state %0d rails %b want 3 %b",
                         r, seq_state, dut_rails(), exp_rails(6));
    end
    for (int s = 6; s >= 1; s--) begin
      repeat (SW) step();
      checks++;
      if (dut_rails() !== exp_rails(s)) begin
        errors++; $display("FAIL abort_hold s%0d: rails %b want %b", s, dut_rails(), exp_rails(s));
      end
      step();
      checks++;
      if (dut_rails() !== exp_rails(s - 1)) begin
        errors++; $display("FAIL abort_adv s%0d: rails %b want %b", s, dut_rails(), exp_rails(s - 1));
      end
    end
    checks++;
    if (seq_state !== 3'd0 || power_down_done !== 1'b1 || up_cnt !== 0) begin
      errors++; $display("FAIL abort_end: state %0d done %b up_pulses %0d want 0 1 0",
                         seq_state, power_down_done, up_cnt);
    end
    step();
  endtask

  task automatic test_pg_monitor();
    logic [4:0] mask;
    int         want_stage;
    set_all_pg(1'b1);
    flt_cnt = 0;
    advance_to_stage(13);
    checks++;
    if (seq_state !== 3'd2) begin
      errors++; $display("FAIL mon_on: state %0d want 2", seq_state);
    end
    AUX_3V3_PG = 1'b0;
    repeat (DG - 1) step();
    AUX_3V3_PG = 1'b1;
    repeat (3) step();
    checks++;
    if (seq_state !== 3'd2 || flt_cnt !== 0) begin
      errors++; $display("FAIL mon_glitch: state %0d faults %0d want 2 0", seq_state, flt_cnt);
    end
    // Drop a random set of gating PGs together; the lowest stage is reported.
    mask = 5'($urandom_range(1, 31));
    want_stage = mask[0] ? 1 : mask[1] ? 4 : mask[2] ? 10 : mask[3] ? 11 : 12;
    {MGT_AVCCPLL_PG, MGT_AVTTX_PG, MGT_AVCC_PG, AUX_3V3_PG, ATX_PWR_OK} = ~mask;
    repeat (DG - 1) step();
    checks++;
    if (seq_state !== 3'd2 || flt_cnt !== 0) begin
      errors++; $display("FAIL mon_early mask %b: state %0d faults %0d want 2 0",
                         mask, seq_state, flt_cnt);
    end
    step();
    set_all_pg(1'b1);
`ifdef PWR_SEQ_PG_MONITOR_EN
    checks++;
    if (seq_state !== 3'd4 || fault !== 1'b1 || fault_stage !== 4'(want_stage) ||
        dut_rails() !== exp_rails(0)) begin
      errors++; $display("FAIL mon_trip mask %b: state %0d fault %b fstage %0d rails %b want 4 1 %0d %b",
                         mask, seq_state, fault, fault_stage, dut_rails(), want_stage, exp_rails(0));
    end
    pulse_down();
`else
    checks++;
    if (seq_state !== 3'd2 || flt_cnt !== 0 || dut_rails() !== exp_rails(12)) begin
      errors++; $display("FAIL mon_off mask %b (stage %0d): state %0d faults %0d rails %b want 2 0 %b",
                         mask, want_stage, seq_state, flt_cnt, dut_rails(), exp_rails(12));
    end
    pulse_down();
    repeat (12 * (SW + 1)) step();
`endif
    checks++;
    if (seq_state !== 3'd0 || dut_rails() !== exp_rails(0)) begin
      errors++; $display("FAIL mon_exit: state %0d rails %b want 0 %b",
                         seq_state, dut_rails(), exp_rails(0));
    end
    step();
  endtask

  task automatic test_async_reset();
    set_all_pg(1'b1);
    advance_to_stage(9);
    repeat ($urandom_range(0, SW)) step();
    checks++;
    if (dut_rails() !== exp_rails(9)) begin
      errors++; $display("FAIL arst_pre: rails %b want %b", dut_rails(), exp_rails(9));
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (dut_rails() !== exp_rails(0) || seq_state !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL arst_now: rails %b state %0d busy %b want %b 0 0",
                         dut_rails(), seq_state, busy, exp_rails(0));
    end
    step();
    rst = 1'b0;
    repeat (2) step();
    checks++;
    if (seq_state !== 3'd0 || dut_rails() !== exp_rails(0)) begin
      errors++; $display("FAIL arst_after: state %0d rails %b want 0 %b",
                         seq_state, dut_rails(), exp_rails(0));
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_power_down();
    test_pg_timeout();
    test_abort_during_up();
    test_pg_monitor();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/power_rail_sequencer.md
Name: power_rail_sequencer

Overview:
Sequences the board supplies on the monitor clock domain: ATX supply, FET gate drivers, POL regulator inhibits and MGT rail enables, in a fixed order. Power-good inputs gate progress. Power-down runs in reverse order. A missing or lost power-good triggers an immediate all-off fault shutdown. Driven by the power manager's power_up/power_down strobes; reports done pulses and fault status back to it.

Parameters:
STEP_WAIT, 32'h0003_ffff, cycles dwelt at each stage before advancing (up or down)
PG_TIMEOUT, 32'h003f_ffff, max cycles to wait for a gating power-good after STEP_WAIT expires
PG_DEGLITCH, 8'd16, consecutive cycles a gating PG must be low while ON before a fault is declared

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  reset, asynchronous, active-high
power_up  in  1  1-cycle strobe: start power-up sequence
power_down  in  1  1-cycle strobe: start power-down sequence / clear fault
power_up_done  out  1  1-cycle pulse: all stages on
power_down_done  out  1  1-cycle pulse: all stages off
busy  out  1  sequence in progress (UP or DOWN state)
fault  out  1  1-cycle pulse on fault entry
fault_stage  out  4  stage index at which the last fault occurred
seq_state  out  3  current state encoding
ATX_PS_ON_N  out  1  ATX on, active-low
ATX_PWR_OK  in  1  ATX power good
G12V_EN, G5V_EN, G3V3_EN  out  1 each  FET gate enables
AUX_3V3_PG  in  1  3V3 power good
TRACK_2V5  out  1  2V5 tracking enable
INHIBIT_2V5, INHIBIT_1V8, INHIBIT_1V5, INHIBIT_1V2, INHIBIT_1V0  out  1 each  POL inhibits, active-high
MGT_AVCC_EN, MGT_AVTTX_EN, MGT_AVCCPLL_EN  out  1 each  MGT rail enables
MGT_AVCC_PG, MGT_AVTTX_PG, MGT_AVCCPLL_PG  in  1 each  MGT power goods

Behaviour:
- Reset (asynchronous): state OFF, stage 0, counters 0, ATX_PS_ON_N=1, all INHIBIT=1, TRACK_2V5=0, all *_EN=0, pulses 0, busy 0, fault_stage 0.
- Stage register 0..12; stage k means stages 1..k active: 1 ATX_PS_ON_N=0 (gate ATX_PWR_OK); 2 G12V_EN; 3 G5V_EN; 4 G3V3_EN (gate AUX_3V3_PG); 5 INHIBIT_2V5=0 and TRACK_2V5=1; 6 INHIBIT_1V8=0; 7 INHIBIT_1V5=0; 8 INHIBIT_1V2=0; 9 INHIBIT_1V0=0; 10 MGT_AVCC_EN (gate MGT_AVCC_PG); 11 MGT_AVTTX_EN (gate PG); 12 MGT_AVCCPLL_EN (gate PG).
- Rail outputs are flops decoded from the next stage value; they change on the same edge as the stage register. No glitches.
- States: OFF=0, UP=1, ON=2, DOWN=3, FAULT=4.
- OFF: power_up -> stage 1, UP, counter cleared.
- UP: dwell STEP_WAIT cycles. Then for a gated stage, wait for its PG, counting to PG_TIMEOUT. Timeout -> FAULT. PG high (or ungated stage) -> stage+1. At stage 12 complete -> ON, power_up_done pulses on the same edge.
- ON: power_up ignored; power_down -> DOWN.
- DOWN: each STEP_WAIT cycles stage-1. Reaching 0 -> OFF, power_down_done pulses. PG inputs ignored.
- power_down during UP: enter DOWN from the current stage, dwell counter cleared. power_down wins over a simultaneous power_up.
- power_up during DOWN or FAULT: ignored.
- FAULT entry: stage forced to 0 on the same edge (all rails off at once), fault pulses, fault_stage latched. Stays in FAULT until power_down, then -> OFF with power_down_done pulse.
- busy = state UP or DOWN.
- Counters saturate and never wrap.
- Reset mid-sequence: all rails off asynchronously.

Optional Feature:
PWR_SEQ_PG_MONITOR_EN: when defined, in ON, any gating PG (ATX_PWR_OK, AUX_3V3_PG, three MGT PGs) low for PG_DEGLITCH consecutive cycles -> FAULT. fault_stage = lowest failing stage index (1, 4, 10, 11, 12). Low runs shorter than PG_DEGLITCH are ignored and the count resets when PG returns high. When undefined, PGs are checked only during UP, and ON exits only via power_down.

Test Plan:
1. STEP_WAIT=4, all PGs tied high; power_up -> stages advance every 5 cycles; rail outputs follow the listed order; power_up_done pulses once; seq_state=2.
2. From ON, power_down -> rails release in reverse order, one stage per STEP_WAIT dwell; power_down_done pulses once; all outputs equal reset values.
3. PG_TIMEOUT=20, MGT_AVTTX_PG held low -> after dwell+20 cycles fault pulses; fault_stage=11; all rails off on the same edge; seq_state=4. A later power_up is ignored; power_down -> OFF with power_down_done.
4. power_down asserted at stage 6 during UP, together with power_up -> state DOWN; stages descend 6->0; power_up_done never pulses.
5. Macro defined, PG_DEGLITCH=3, in ON: AUX_3V3_PG low for 2 cycles -> no fault. Low for 3 cycles -> fault; fault_stage=4. Macro undefined: same stimulus produces no fault.
6. Assert wb_rst_i at stage 9 -> outputs return to reset values immediately, without waiting for a clock edge; state OFF.
